// File: rtl/sap_pkg.sv
// sap_pkg: shared state encoding and sizing helpers for the SAP building blocks
package sap_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  // Bit-counter width for a WIDTH-bit serial operation (at least one bit)
  function automatic int cnt_width(int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/fa.sv
// fa: 1-bit full-adder cell
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial A-B through one full-adder cell with START/DONE handshake
module serial_sub
  import sap_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW,
  output logic             ZERO
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, part_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             cy_q, busy_q, done_q, borrow_q, zero_q;
  logic             s, co;
  logic [WIDTH-1:0] part_d;
  logic             last;
  fa u_fa (.a_i(a_q[0]), .b_i(b_q[0]), .c_i(cy_q), .s_o(s), .c_o(co));
  // Sum bits enter at the MSB so the first bit ends up in bit 0 after WIDTH shifts
  always_comb begin
    part_d = {s, part_q[WIDTH-1:1]};
    last   = (cnt_q == CW'(WIDTH - 1));
  end
  // Control FSM, serial datapath and held result registers
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
    end else if (state_q == S_SHIFT) begin
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      part_q <= part_d;
      cy_q   <= co;
      cnt_q  <= cnt_q + 1'b1;
      if (last) begin
        state_q  <= S_DONE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        diff_q   <= part_d;
        borrow_q <= ~co;
        zero_q   <= (part_d == '0);
      end
    end else if (START) begin
      state_q <= S_SHIFT;
      a_q     <= A;
      b_q     <= ~B;
      part_q  <= '0;
      cy_q    <= 1'b1;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end
  end
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign DIFF   = diff_q;
  assign BORROW = borrow_q;
  assign ZERO   = zero_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed self-checking bench for serial_sub (WIDTH=4)
module tb_serial_sub;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       busy, done, borrow, zero;
  logic [3:0] diff;
  int         n_cmp = 0, n_bad = 0;

  serial_sub #(.WIDTH(4)) dut (
    .CLK(clk), .CLR(clr), .START(start), .A(a), .B(b),
    .BUSY(busy), .DONE(done), .DIFF(diff), .BORROW(borrow), .ZERO(zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".diff"}, 32'(diff), 32'd0);
    chk({tag, ".borrow"}, 32'(borrow), 32'd0);
    chk({tag, ".zero"}, 32'(zero), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                        input logic [3:0] ed, input logic eb, input logic ez);
    a = ai; b = bi; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".done_early"}, 32'(done), 32'd0);
      step();
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, ".diff"}, 32'(diff), 32'(ed));
    chk({tag, ".borrow"}, 32'(borrow), 32'(eb));
    chk({tag, ".zero"}, 32'(zero), 32'(ez));
    step();
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".diff_hold"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    step();
    step();
    clr = 1'b0;
    step();
    chk_reset("reset");

    run_op("sub_9_3", 4'd9, 4'd3, 4'd6, 1'b0, 1'b0);
    run_op("sub_3_9", 4'd3, 4'd9, 4'hA, 1'b1, 1'b0);
    run_op("sub_5_5", 4'd5, 4'd5, 4'd0, 1'b0, 1'b1);
    run_op("sub_0_f", 4'd0, 4'hF, 4'd1, 1'b1, 1'b0);

    a = 4'd7; b = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 4'hF; b = 4'hF;
    step();
    chk("ign.done_mid", 32'(done), 32'd0);
    start = 1'b0;
    step();
    chk("ign.busy_mid", 32'(busy), 32'd1);
    step();
    chk("ign.done", 32'(done), 32'd1);
    chk("ign.diff", 32'(diff), 32'd5);
    chk("ign.borrow", 32'(borrow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ign.no_second_done", 32'(done), 32'd0);
      chk("ign.diff_hold", 32'(diff), 32'd5);
    end

    a = 4'd8; b = 4'd1; start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    step();
    chk("b2b.done1", 32'(done), 32'd1);
    chk("b2b.diff1", 32'(diff), 32'd7);
    chk("b2b.borrow1", 32'(borrow), 32'd0);
    a = 4'd2; b = 4'd4;
    step();
    start = 1'b0;
    chk("b2b.busy2", 32'(busy), 32'd1);
    chk("b2b.done_gap", 32'(done), 32'd0);
    chk("b2b.diff_hold", 32'(diff), 32'd7);
    for (int i = 0; i < 3; i++) step();
    chk("b2b.done_gap2", 32'(done), 32'd0);
    step();
    chk("b2b.done2", 32'(done), 32'd1);
    chk("b2b.diff2", 32'(diff), 32'hE);
    chk("b2b.borrow2", 32'(borrow), 32'd1);
    step();

    a = 4'd6; b = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_reset("abort");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort.no_done", 32'(done), 32'd0);
      chk("abort.no_busy", 32'(busy), 32'd0);
    end
    run_op("after_abort", 4'd6, 4'd1, 4'd5, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
